// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback controller and its FIFO.
// No logic here; widths mirror the register file (32 regs x 32 bits).
// wb_entry_t is the unit of storage: one sanitised writeback pair.
package wb_pkg;

    localparam int WB_AW    = 5;
    localparam int WB_DW    = 32;
    localparam int WB_LANES = 2;

    localparam logic [WB_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [WB_LANES-1:0] we;     // bit0 = lane1, bit1 = lane2
        logic [WB_AW-1:0]    reg1;
        logic [WB_AW-1:0]    reg2;
        logic [WB_DW-1:0]    data1;
        logic [WB_DW-1:0]    data2;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_ctrl_if.sv
// Writeback request bundle from execute into the writeback controller.
// Purely wiring; no latency.
// Backpressure: req_ready from the controller, transfer when req_valid && req_ready.
interface regfile_writeback_ctrl_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_we;
    logic [AW-1:0] req_reg1;
    logic [AW-1:0] req_reg2;
    logic [DW-1:0] req_data1;
    logic [DW-1:0] req_data2;

    modport master (
        output req_valid, req_we, req_reg1, req_reg2, req_data1, req_data2,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_we, req_reg1, req_reg2, req_data1, req_data2,
        output req_ready
    );
endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of writeback pairs with a flat view of all slots for forwarding.
// Push lands on the next edge; head is combinational from storage.
// No internal backpressure: the caller must not push when full nor pop when empty.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  wb_entry_t                 push_ent,
    input  logic                      pop,
    output wb_entry_t                 head,
    output logic [CW-1:0]             count,
    output logic [PW-1:0]             rd_ptr,
    output wb_entry_t [DEPTH-1:0]     ents
);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    // Next-state: write at tail, advance pointers, count tracks net change.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_ent;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // State registers; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head   = mem_q[rd_ptr_q];
    assign count  = count_q;
    assign rd_ptr = rd_ptr_q;
    assign ents   = mem_q;

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Buffers paired writeback results and drains one pair per cycle to the register file; forwards pending data.
// Latency: push to RegWrite_signal strobe is 2 edges when empty and unstalled; forwarding is combinational.
// Backpressure: req_ready drops when the FIFO is full; rf_stall holds the head and zeroes strobes.
module regfile_writeback_ctrl
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    regfile_writeback_ctrl_if.slave  req,
    input  logic                     rf_stall,
    output logic [WB_LANES-1:0]      RegWrite_signal,
    output logic [AW-1:0]            WriteReg1,
    output logic [AW-1:0]            WriteReg2,
    output logic [DW-1:0]            WriteData1,
    output logic [DW-1:0]            WriteData2,
    input  logic [AW-1:0]            fwd_addr_a,
    input  logic [AW-1:0]            fwd_addr_b,
    output logic                     fwd_hit_a,
    output logic [DW-1:0]            fwd_data_a,
    output logic                     fwd_hit_b,
    output logic [DW-1:0]            fwd_data_b,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t             push_ent, head;
    wb_entry_t [DEPTH-1:0] fifo_ents;
    logic [CW-1:0]         fifo_count;
    logic [PW-1:0]         fifo_rd_ptr;
    logic [WB_LANES-1:0]   san_we;
    logic                  do_push, do_pop;

    logic [WB_LANES-1:0]   regwrite_q, regwrite_d;
    logic [AW-1:0]         write_reg1_q, write_reg1_d, write_reg2_q, write_reg2_d;
    logic [DW-1:0]         write_data1_q, write_data1_d, write_data2_q, write_data2_d;

    // Ready depends only on occupancy so execute never sees a combinational path from rf_stall.
    assign req.req_ready = (fifo_count != CW'(DEPTH));

    // Sanitise lanes: r0 writes vanish, a same-destination pair keeps only lane2, empty pairs are dropped.
    always_comb begin
        san_we = req.req_we;
        if (req.req_reg1 == REG_ZERO) san_we[0] = 1'b0;
        if (req.req_reg2 == REG_ZERO) san_we[1] = 1'b0;
        if (san_we == 2'b11 && req.req_reg1 == req.req_reg2) san_we[0] = 1'b0;
        push_ent = '{we: san_we, reg1: req.req_reg1, reg2: req.req_reg2,
                     data1: req.req_data1, data2: req.req_data2};
        do_push  = req.req_valid && req.req_ready && (san_we != '0);
        do_pop   = (fifo_count != '0) && !rf_stall;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (do_push),
        .push_ent (push_ent),
        .pop      (do_pop),
        .head     (head),
        .count    (fifo_count),
        .rd_ptr   (fifo_rd_ptr),
        .ents     (fifo_ents)
    );

    // Output stage: strobes pulse only on a pop; address/data hold otherwise.
    always_comb begin
        regwrite_d    = '0;
        write_reg1_d  = write_reg1_q;
        write_reg2_d  = write_reg2_q;
        write_data1_d = write_data1_q;
        write_data2_d = write_data2_q;
        if (do_pop) begin
            regwrite_d    = head.we;
            write_reg1_d  = head.reg1;
            write_reg2_d  = head.reg2;
            write_data1_d = head.data1;
            write_data2_d = head.data2;
        end
    end

    // Output stage registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_q    <= '0;
            write_reg1_q  <= '0;
            write_reg2_q  <= '0;
            write_data1_q <= '0;
            write_data2_q <= '0;
        end else begin
            regwrite_q    <= regwrite_d;
            write_reg1_q  <= write_reg1_d;
            write_reg2_q  <= write_reg2_d;
            write_data1_q <= write_data1_d;
            write_data2_q <= write_data2_d;
        end
    end

    assign RegWrite_signal = regwrite_q;
    assign WriteReg1       = write_reg1_q;
    assign WriteReg2       = write_reg2_q;
    assign WriteData1      = write_data1_q;
    assign WriteData2      = write_data2_q;
    assign busy            = (fifo_count != '0) || (regwrite_q != '0);

    // Scan oldest to newest so later matches overwrite earlier ones; lane2 checked after lane1.
    function automatic logic [DW:0] fwd_lookup(input logic [AW-1:0] addr);
        logic          hit;
        logic [DW-1:0] dat;
        wb_entry_t     e;
        logic [PW-1:0] idx;
        hit = 1'b0;
        dat = '0;
        if (regwrite_q[0] && write_reg1_q == addr) begin hit = 1'b1; dat = write_data1_q; end
        if (regwrite_q[1] && write_reg2_q == addr) begin hit = 1'b1; dat = write_data2_q; end
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(fifo_count)) begin
                idx = fifo_rd_ptr + PW'(i);
                e   = fifo_ents[idx];
                if (e.we[0] && e.reg1 == addr) begin hit = 1'b1; dat = e.data1; end
                if (e.we[1] && e.reg2 == addr) begin hit = 1'b1; dat = e.data2; end
            end
        end
        if (addr == REG_ZERO) begin
            hit = 1'b0;
            dat = '0;
        end
        return {hit, dat};
    endfunction

    // Two independent forwarding ports for decode's source operands.
    always_comb begin
        {fwd_hit_a, fwd_data_a} = fwd_lookup(fwd_addr_a);
        {fwd_hit_b, fwd_data_b} = fwd_lookup(fwd_addr_b);
    end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Scoreboard bench for regfile_writeback_ctrl: a reference queue model predicts
// every strobe, ready and busy value; scenario tasks add targeted checks.
module tb_regfile_writeback_ctrl;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rf_stall;
    logic [1:0]  RegWrite_signal;
    logic [4:0]  WriteReg1, WriteReg2, fwd_addr_a, fwd_addr_b;
    logic [31:0] WriteData1, WriteData2, fwd_data_a, fwd_data_b;
    logic        fwd_hit_a, fwd_hit_b, busy;

    always #5 clk = ~clk;

    regfile_writeback_ctrl_if #(.AW(5), .DW(32)) req_if ();

    regfile_writeback_ctrl #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req             (req_if),
        .rf_stall        (rf_stall),
        .RegWrite_signal (RegWrite_signal),
        .WriteReg1       (WriteReg1),
        .WriteReg2       (WriteReg2),
        .WriteData1      (WriteData1),
        .WriteData2      (WriteData2),
        .fwd_addr_a      (fwd_addr_a),
        .fwd_addr_b      (fwd_addr_b),
        .fwd_hit_a       (fwd_hit_a),
        .fwd_data_a      (fwd_data_a),
        .fwd_hit_b       (fwd_hit_b),
        .fwd_data_b      (fwd_data_b),
        .busy            (busy)
    );

    int        total = 0;
    int        bad   = 0;
    wb_entry_t sb_q[$];
    wb_entry_t exp_out;
    bit        last_accept = 0;
    bit        mon_en = 0;

    function automatic wb_entry_t sanitize(input logic [1:0] we, input logic [4:0] r1, r2,
                                           input logic [31:0] d1, d2);
        wb_entry_t s;
        s.we = we; s.reg1 = r1; s.reg2 = r2; s.data1 = d1; s.data2 = d2;
        if (r1 == 5'd0) s.we[0] = 1'b0;
        if (r2 == 5'd0) s.we[1] = 1'b0;
        if (s.we == 2'b11 && r1 == r2) s.we[0] = 1'b0;
        return s;
    endfunction

    // Reference model: queue of pending pairs plus predicted output stage.
    always @(posedge clk or negedge rst_n) begin
        wb_entry_t s;
        bit acc, pop;
        if (!rst_n) begin
            sb_q.delete();
            exp_out     = '0;
            last_accept = 0;
        end else begin
            acc = req_if.req_valid && (sb_q.size() != DEPTH);
            pop = (sb_q.size() != 0) && !rf_stall;
            last_accept = acc;
            if (pop) exp_out = sb_q.pop_front();
            else     exp_out.we = 2'b00;
            if (acc) begin
                s = sanitize(req_if.req_we, req_if.req_reg1, req_if.req_reg2,
                             req_if.req_data1, req_if.req_data2);
                if (s.we != 2'b00) sb_q.push_back(s);
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        bit exp_rdy, exp_busy;
        if (mon_en && rst_n) begin
            exp_rdy  = (sb_q.size() != DEPTH);
            exp_busy = (sb_q.size() != 0) || (exp_out.we != 2'b00);
            total++;
            if (req_if.req_ready !== exp_rdy) begin
                bad++; $display("FAIL mon_ready t=%0t got=%b exp=%b", $time, req_if.req_ready, exp_rdy);
            end
            total++;
            if (RegWrite_signal !== exp_out.we) begin
                bad++; $display("FAIL mon_strobe t=%0t got=%b exp=%b", $time, RegWrite_signal, exp_out.we);
            end
            total++;
            if (busy !== exp_busy) begin
                bad++; $display("FAIL mon_busy t=%0t got=%b exp=%b", $time, busy, exp_busy);
            end
            if (exp_out.we[0]) begin
                total++;
                if (WriteReg1 !== exp_out.reg1 || WriteData1 !== exp_out.data1) begin
                    bad++; $display("FAIL mon_lane1 t=%0t got=%0d/%h exp=%0d/%h", $time,
                                    WriteReg1, WriteData1, exp_out.reg1, exp_out.data1);
                end
            end
            if (exp_out.we[1]) begin
                total++;
                if (WriteReg2 !== exp_out.reg2 || WriteData2 !== exp_out.data2) begin
                    bad++; $display("FAIL mon_lane2 t=%0t got=%0d/%h exp=%0d/%h", $time,
                                    WriteReg2, WriteData2, exp_out.reg2, exp_out.data2);
                end
            end
        end
    end

    // Offer one pair and hold it until the handshake completes (bounded).
    task automatic push(input logic [1:0] we, input logic [4:0] r1, r2, input logic [31:0] d1, d2);
        int n = 0;
        req_if.req_valid = 1'b1;
        req_if.req_we    = we;
        req_if.req_reg1  = r1;
        req_if.req_reg2  = r2;
        req_if.req_data1 = d1;
        req_if.req_data2 = d2;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!last_accept && n < 50);
        if (!last_accept) begin
            total++; bad++;
            $display("FAIL push_timeout got=no_accept exp=accept");
        end
        req_if.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL %s_drain got busy=%b exp=0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (RegWrite_signal !== 2'b00 || WriteReg1 !== 5'd0 || WriteReg2 !== 5'd0 ||
            WriteData1 !== 32'd0 || WriteData2 !== 32'd0) begin
            bad++; $display("FAIL reset_outputs got=%b %0d %0d %h %h exp=all zero",
                            RegWrite_signal, WriteReg1, WriteReg2, WriteData1, WriteData2);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        total++;
        if (req_if.req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_ready_busy got=%b/%b exp=1/0", req_if.req_ready, busy);
        end
        mon_en = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        push(2'b01, 5'd3, 5'd0, 32'hA5A5_0001, 32'd0);
        total++;
        if (RegWrite_signal !== 2'b00) begin
            bad++; $display("FAIL lat_edge1 got=%b exp=00", RegWrite_signal);
        end
        @(posedge clk); #1;
        total++;
        if (RegWrite_signal !== 2'b01 || WriteReg1 !== 5'd3 || WriteData1 !== 32'hA5A5_0001) begin
            bad++; $display("FAIL lat_edge2 got=%b %0d %h exp=01 3 a5a50001",
                            RegWrite_signal, WriteReg1, WriteData1);
        end
        @(posedge clk); #1;
        total++;
        if (RegWrite_signal !== 2'b00) begin
            bad++; $display("FAIL lat_edge3 got=%b exp=00", RegWrite_signal);
        end
    endtask

    task automatic test_stall_full();
        rf_stall = 1'b1;
        for (int i = 0; i < 4; i++)
            push(2'b11, 5'(10 + i), 5'(20 + i), 32'(100 + i), 32'(200 + i));
        total++;
        if (req_if.req_ready !== 1'b0) begin
            bad++; $display("FAIL full_ready got=%b exp=0", req_if.req_ready);
        end
        req_if.req_valid = 1'b1;
        req_if.req_we    = 2'b01;
        req_if.req_reg1  = 5'd15;
        req_if.req_reg2  = 5'd0;
        req_if.req_data1 = 32'd555;
        req_if.req_data2 = 32'd0;
        repeat (2) begin @(posedge clk); #1; end
        total++;
        if (req_if.req_ready !== 1'b0 || RegWrite_signal !== 2'b00) begin
            bad++; $display("FAIL stall_hold got ready=%b strobe=%b exp=0/00", req_if.req_ready, RegWrite_signal);
        end
        rf_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (last_accept) req_if.req_valid = 1'b0;
            total++;
            if (RegWrite_signal !== 2'b11 || WriteData1 !== 32'(100 + k) || WriteData2 !== 32'(200 + k)) begin
                bad++; $display("FAIL drain_order k=%0d got=%b %0d %0d exp=11 %0d %0d", k,
                                RegWrite_signal, WriteData1, WriteData2, 100 + k, 200 + k);
            end
        end
        req_if.req_valid = 1'b0;
        wait_idle("stall");
    endtask

    task automatic test_sanitize();
        push(2'b11, 5'd7, 5'd7, 32'd1, 32'd2);
        @(posedge clk); #1;
        total++;
        if (RegWrite_signal !== 2'b10 || WriteReg2 !== 5'd7 || WriteData2 !== 32'd2) begin
            bad++; $display("FAIL same_dest got=%b %0d %0d exp=10 7 2", RegWrite_signal, WriteReg2, WriteData2);
        end
        push(2'b01, 5'd0, 5'd0, 32'd123, 32'd0);
        @(posedge clk); #1;
        total++;
        if (RegWrite_signal !== 2'b00 || busy !== 1'b0) begin
            bad++; $display("FAIL reg0_drop got=%b busy=%b exp=00 0", RegWrite_signal, busy);
        end
    endtask

    task automatic test_forward();
        rf_stall = 1'b1;
        push(2'b01, 5'd9, 5'd0, 32'd10, 32'd0);
        push(2'b01, 5'd9, 5'd0, 32'd20, 32'd0);
        fwd_addr_a = 5'd9;
        fwd_addr_b = 5'd0;
        #1;
        total++;
        if (fwd_hit_a !== 1'b1 || fwd_data_a !== 32'd20) begin
            bad++; $display("FAIL fwd_newest got=%b %0d exp=1 20", fwd_hit_a, fwd_data_a);
        end
        total++;
        if (fwd_hit_b !== 1'b0 || fwd_data_b !== 32'd0) begin
            bad++; $display("FAIL fwd_zero got=%b %0d exp=0 0", fwd_hit_b, fwd_data_b);
        end
        push(2'b11, 5'd4, 5'd9, 32'd40, 32'd30);
        fwd_addr_b = 5'd4;
        #1;
        total++;
        if (fwd_hit_a !== 1'b1 || fwd_data_a !== 32'd30 || fwd_hit_b !== 1'b1 || fwd_data_b !== 32'd40) begin
            bad++; $display("FAIL fwd_lane2 got=%b %0d %b %0d exp=1 30 1 40",
                            fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b);
        end
        fwd_addr_b = 5'd12;
        #1;
        total++;
        if (fwd_hit_b !== 1'b0 || fwd_data_b !== 32'd0) begin
            bad++; $display("FAIL fwd_miss got=%b %0d exp=0 0", fwd_hit_b, fwd_data_b);
        end
        rf_stall = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        total++;
        if (fwd_hit_a !== 1'b1 || fwd_data_a !== 32'd30) begin
            bad++; $display("FAIL fwd_outstage got=%b %0d exp=1 30", fwd_hit_a, fwd_data_a);
        end
        @(posedge clk); #1;
        total++;
        if (fwd_hit_a !== 1'b0 || fwd_data_a !== 32'd0) begin
            bad++; $display("FAIL fwd_retired got=%b %0d exp=0 0", fwd_hit_a, fwd_data_a);
        end
        fwd_addr_a = 5'd0;
        fwd_addr_b = 5'd0;
    endtask

    task automatic test_back_to_back();
        rf_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push(2'b01, 5'(1 + i), 5'd0, 32'h1000 + 32'(i), 32'd0);
            total++;
            if (req_if.req_ready !== 1'b1) begin
                bad++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, req_if.req_ready);
            end
        end
        wait_idle("b2b");
    endtask

    task automatic test_reset_midop();
        rf_stall = 1'b1;
        for (int i = 0; i < 4; i++)
            push(2'b01, 5'(20 + i), 5'd0, 32'(300 + i), 32'd0);
        rf_stall = 1'b0;
        @(posedge clk); #1;
        total++;
        if (RegWrite_signal !== 2'b01 || WriteData1 !== 32'd300) begin
            bad++; $display("FAIL midop_pre got=%b %0d exp=01 300", RegWrite_signal, WriteData1);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (RegWrite_signal !== 2'b00 || WriteReg1 !== 5'd0 || WriteData1 !== 32'd0 ||
            busy !== 1'b0 || req_if.req_ready !== 1'b1) begin
            bad++; $display("FAIL midop_reset got=%b %0d %0d busy=%b rdy=%b exp=00 0 0 0 1",
                            RegWrite_signal, WriteReg1, WriteData1, busy, req_if.req_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            total++;
            if (RegWrite_signal !== 2'b00 || busy !== 1'b0) begin
                bad++; $display("FAIL midop_after k=%0d got=%b busy=%b exp=00 0", k, RegWrite_signal, busy);
            end
        end
    endtask

    initial begin
        rf_stall         = 1'b0;
        fwd_addr_a       = '0;
        fwd_addr_b       = '0;
        req_if.req_valid = 1'b0;
        req_if.req_we    = '0;
        req_if.req_reg1  = '0;
        req_if.req_reg2  = '0;
        req_if.req_data1 = '0;
        req_if.req_data2 = '0;
        test_reset();
        test_latency();
        test_stall_full();
        test_sanitize();
        test_forward();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
